// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared width and boot-sequencer state type for the MIPS boot controller.
// Revision : 1.0
// ============================================================================
package mips_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4
    } boot_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_dbg_read_port.sv
`default_nettype none
// ============================================================================
// Module   : mips_dbg_read_port
// Brief    : Two-stage data-memory debug read sequencer, one read outstanding.
// Revision : 1.0
// ============================================================================
module mips_dbg_read_port #(
    parameter int WIDTH = mips_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n_in,
    input  logic             enable_in,
    input  logic             dbg_req_in,
    input  logic [WIDTH-1:0] dbg_addr_in,
    input  logic [WIDTH-1:0] read_data_in,
    output logic [WIDTH-1:0] read_data_address_out,
    output logic             dbg_ack_out,
    output logic [WIDTH-1:0] dbg_data_out
);

    logic             r_pending;
    logic             r_ack;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;

    // A request arriving while the previous one is still on the address bus is dropped.
    assign w_accept = enable_in && dbg_req_in && !r_pending;

    always_ff @(posedge clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_pending <= w_accept;
            r_ack     <= r_pending;
            if (w_accept) begin
                r_addr <= dbg_addr_in;
            end
            if (r_pending) begin
                r_data <= read_data_in;
            end
        end
    end

    assign read_data_address_out = r_addr;
    assign dbg_ack_out           = r_ack;
    assign dbg_data_out          = r_data;

endmodule
`default_nettype wire

// File: rtl/mips_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_boot_ctrl
// Brief    : Boot/run sequencer: program load, flush, budgeted run, halt, debug reads.
// Revision : 1.0
// ============================================================================
module mips_boot_ctrl #(
    parameter int WIDTH        = mips_pkg::WIDTH,
    parameter int DEPTH        = 256,
    parameter int FLUSH_CYCLES = 2,
    parameter int RUN_W        = 16
) (
    input  logic                   clock,
    input  logic                   reset_n_in,
    input  logic                   start_in,
    input  logic                   abort_in,
    input  logic [$clog2(DEPTH):0] word_count_in,
    input  logic [RUN_W-1:0]       run_cycles_in,
    input  logic                   wr_valid_in,
    input  logic [WIDTH-1:0]       wr_data_in,
    output logic                   wr_ready_out,
    output logic                   instrWrite_out,
    output logic [WIDTH-1:0]       instr_address_out,
    output logic [WIDTH-1:0]       instr_out,
    output logic                   core_reset_out,
    output logic [WIDTH-1:0]       read_data_address_out,
    input  logic [WIDTH-1:0]       read_data_in,
    input  logic                   dbg_req_in,
    input  logic [WIDTH-1:0]       dbg_addr_in,
    output logic                   dbg_ack_out,
    output logic [WIDTH-1:0]       dbg_data_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   error_out
);
    import mips_pkg::*;

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int FLUSH_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    localparam logic [CNT_W-1:0]   c_depth      = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   c_cnt_one    = CNT_W'(1);
    localparam logic [FLUSH_W-1:0] c_flush_one  = FLUSH_W'(1);
    localparam logic [FLUSH_W-1:0] c_flush_last = FLUSH_W'(FLUSH_CYCLES);
    localparam logic [RUN_W-1:0]   c_run_one    = RUN_W'(1);

    boot_state_t        r_state;
    boot_state_t        w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_index;
    logic [RUN_W-1:0]   r_budget;
    logic [RUN_W-1:0]   r_run_cnt;
    logic [FLUSH_W-1:0] r_flush_cnt;
    logic               r_error;
    logic               r_wr_strobe;
    logic [WIDTH-1:0]   r_instr_address;
    logic [WIDTH-1:0]   r_instr;

    logic w_idle_or_halt;
    logic w_count_ok;
    logic w_start_accept;
    logic w_start_reject;
    logic w_handshake;
    logic w_last_word;
    logic w_budget_done;

    assign w_idle_or_halt = (r_state == IDLE) || (r_state == HALT);
    assign w_count_ok     = (word_count_in != '0) && (word_count_in <= c_depth);
    // Abort takes priority over a simultaneous start.
    assign w_start_accept = w_idle_or_halt && start_in && !abort_in && w_count_ok;
    assign w_start_reject = w_idle_or_halt && start_in && !abort_in && !w_count_ok;
    assign w_handshake    = (r_state == LOAD) && wr_valid_in;
    assign w_last_word    = w_handshake && (r_index == r_count - c_cnt_one);
    assign w_budget_done  = (r_budget != '0) && (r_run_cnt == r_budget - c_run_one);

    always_comb begin
        w_state_next   = r_state;
        wr_ready_out   = 1'b0;
        busy_out       = 1'b0;
        done_out       = 1'b0;
        core_reset_out = 1'b1;
        case (r_state)
            IDLE: begin
                if (w_start_accept) w_state_next = LOAD;
            end
            LOAD: begin
                wr_ready_out = 1'b1;
                busy_out     = 1'b1;
                if (abort_in)         w_state_next = IDLE;
                else if (w_last_word) w_state_next = FLUSH;
            end
            FLUSH: begin
                // Covers the final strobe cycle plus FLUSH_CYCLES quiet cycles.
                busy_out = 1'b1;
                if (abort_in)                          w_state_next = IDLE;
                else if (r_flush_cnt == c_flush_last)  w_state_next = RUN;
            end
            RUN: begin
                busy_out       = 1'b1;
                core_reset_out = 1'b0;
                if (abort_in || w_budget_done) w_state_next = HALT;
            end
            HALT: begin
                done_out = 1'b1;
                if (w_start_accept) w_state_next = LOAD;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state         <= IDLE;
            r_count         <= '0;
            r_index         <= '0;
            r_budget        <= '0;
            r_run_cnt       <= '0;
            r_flush_cnt     <= '0;
            r_error         <= 1'b0;
            r_wr_strobe     <= 1'b0;
            r_instr_address <= '0;
            r_instr         <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wr_strobe <= w_handshake;
            if (w_handshake) begin
                r_instr_address <= WIDTH'({r_index, 2'b00});
                r_instr         <= wr_data_in;
                r_index         <= r_index + c_cnt_one;
            end
            if (w_start_accept) begin
                r_count  <= word_count_in;
                r_budget <= run_cycles_in;
                r_index  <= '0;
            end
            r_flush_cnt <= (r_state == FLUSH) ? r_flush_cnt + c_flush_one : '0;
            r_run_cnt   <= (r_state == RUN) ? r_run_cnt + c_run_one : '0;
            if (w_start_reject) begin
                r_error <= 1'b1;
            end else if (w_start_accept) begin
                r_error <= 1'b0;
            end else if (abort_in && ((r_state == LOAD) || (r_state == FLUSH))) begin
                r_error <= 1'b1;
            end
        end
    end

    assign instrWrite_out    = r_wr_strobe;
    assign instr_address_out = r_instr_address;
    assign instr_out         = r_instr;
    assign error_out         = r_error;

    mips_dbg_read_port #(
        .WIDTH (WIDTH)
    ) u_dbg_read_port (
        .clock                 (clock),
        .reset_n_in            (reset_n_in),
        .enable_in             (w_idle_or_halt),
        .dbg_req_in            (dbg_req_in),
        .dbg_addr_in           (dbg_addr_in),
        .read_data_in          (read_data_in),
        .read_data_address_out (read_data_address_out),
        .dbg_ack_out           (dbg_ack_out),
        .dbg_data_out          (dbg_data_out)
    );

endmodule
`default_nettype wire
